// File: rtl/sp_32xn_pkt_buf_pkg.sv
// Shared types and sizing for the store-and-forward packet buffer.
package sp_32xn_pkt_buf_pkg;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    // Highest RAM index; a packet reaching it is closed whether or not s_last is set.
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/sp_32xn_pkt_buf_if.sv
// Valid/ready word stream with an end-of-packet marker.
interface sp_32xn_pkt_buf_if #(
    parameter int unsigned DW = 4
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/sp_32xn_pmt.sv
// 32-deep single-port distributed RAM: synchronous write, combinational read.
module sp_32xn_pmt
    import sp_32xn_pkt_buf_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic          wclk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge wclk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/sp_32xn_pkt_buf.sv
// Half-duplex store-and-forward packet buffer: fill one packet (1..32 words), then replay it.
module sp_32xn_pkt_buf
    import sp_32xn_pkt_buf_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    sp_32xn_pkt_buf_if.slave      s,
    sp_32xn_pkt_buf_if.master     m,
    output logic                  trunc,
    output logic                  busy
);

    pkt_state_e    state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] len_q;
    logic          trunc_q;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;

    sp_32xn_pmt #(
        .DW(DW)
    ) u_ram (
        .wclk (wclk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (s.data),
        .dout (ram_dout)
    );

    // Controller: pointers, packet length, state and the registered truncation pulse.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            trunc_q  <= 1'b0;
        end else begin
            trunc_q <= 1'b0;
            unique case (state_q)
                FILL: begin
                    if (s.valid) begin
                        if (s.last || (wr_ptr_q == LAST_IDX)) begin
                            // Closing word: wr_ptr is left alone so it never steps past 31.
                            len_q    <= wr_ptr_q;
                            rd_ptr_q <= '0;
                            state_q  <= DRAIN;
                            trunc_q  <= !s.last;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (m.ready) begin
                        if (rd_ptr_q == len_q) begin
                            wr_ptr_q <= '0;
                            state_q  <= FILL;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Handshake outputs and RAM port ownership, all derived from state (no s_* to m_* path).
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = rd_ptr_q;
        s.ready  = 1'b0;
        m.valid  = 1'b0;
        m.last   = 1'b0;
        if (state_q == FILL) begin
            s.ready  = 1'b1;
            ram_we   = s.valid;
            ram_addr = wr_ptr_q;
        end else begin
            m.valid  = 1'b1;
            m.last   = (rd_ptr_q == len_q);
        end
    end

    assign m.data = ram_dout;
    assign trunc  = trunc_q;
    assign busy   = (state_q == DRAIN);

endmodule

// File: tb/tb_sp_32xn_pkt_buf.sv
// Bench for sp_32xn_pkt_buf: table vectors, directed corner cases and a randomized scoreboard run.
module tb_sp_32xn_pkt_buf;

    localparam int unsigned DW   = 4;
    localparam int          MAXW = 32;

    logic wclk;
    logic rst_n;
    logic trunc;
    logic busy;

    sp_32xn_pkt_buf_if #(.DW(DW)) s_if ();
    sp_32xn_pkt_buf_if #(.DW(DW)) m_if ();

    sp_32xn_pkt_buf #(
        .DW(DW)
    ) dut (
        .wclk  (wclk),
        .rst_n (rst_n),
        .s     (s_if),
        .m     (m_if),
        .trunc (trunc),
        .busy  (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t         in_q[$];      // words still to be offered by the source
    word_t         exp_q[$];     // words the sink must see, in order
    logic [DW-1:0] cur_q[$];     // words of the packet currently being accepted
    bit            mon_en     = 1'b0;
    bit            trunc_due  = 1'b0;
    int            trunc_exp  = 0;
    int            trunc_seen = 0;
    bit            hold_prev  = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    // Packets are framed by s_last or cut after 32 words; each frame is replayed whole.
    always @(negedge wclk) begin
        if (mon_en) begin
            if (trunc || trunc_due) chk("trunc_pulse", int'(trunc), int'(trunc_due));
            if (trunc) trunc_seen++;
            trunc_due = 1'b0;

            chk("half_duplex", int'(s_if.ready), int'(!m_if.valid));
            chk("busy", int'(busy), int'(m_if.valid));

            if (hold_prev) begin
                chk("stall_valid", int'(m_if.valid), 1);
                chk("stall_data", int'(m_if.data), int'(prev_data));
                chk("stall_last", int'(m_if.last), int'(prev_last));
            end
            hold_prev = m_if.valid && !m_if.ready;
            prev_data = m_if.data;
            prev_last = m_if.last;

            if (m_if.valid && m_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("out_data", int'(m_if.data), int'(w.data));
                    chk("out_last", int'(m_if.last), int'(w.last));
                end
            end

            if (s_if.valid && s_if.ready) begin
                cur_q.push_back(s_if.data);
                if (s_if.last || cur_q.size() == MAXW) begin
                    for (int i = 0; i < cur_q.size(); i++) begin
                        exp_q.push_back('{data: cur_q[i], last: (i == cur_q.size() - 1)});
                    end
                    if (!s_if.last) begin
                        trunc_due = 1'b1;
                        trunc_exp++;
                    end
                    cur_q.delete();
                end
            end
        end
    end

    task automatic model_clear();
        in_q.delete();
        exp_q.delete();
        cur_q.delete();
        trunc_due = 1'b0;
        hold_prev = 1'b0;
    endtask

    // Source/sink driver obeying valid/ready; bounded by a cycle budget.
    task automatic drive_stream(input int pv, input int pr, input int budget);
        int cyc = 0;
        bit hold = 1'b0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || cur_q.size() > 0) && cyc < budget) begin
            if (!hold && in_q.size() > 0 && $urandom_range(99) < pv) hold = 1'b1;
            s_if.valid = hold;
            s_if.data  = hold ? in_q[0].data : DW'($urandom);
            s_if.last  = hold ? in_q[0].last : 1'b0;
            m_if.ready = ($urandom_range(99) < pr);
            @(negedge wclk);
            if (hold && s_if.ready) begin
                void'(in_q.pop_front());
                hold = 1'b0;
            end
            @(posedge wclk);
            #1;
            cyc++;
        end
        if (cyc >= budget) chk("stream_timeout", cyc, budget - 1);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          sl;
        logic          mr;
        logic          e_sready;
        logic          e_mvalid;
        logic          chk_d;
        logic [DW-1:0] e_mdata;
        logic          e_mlast;
        logic          e_trunc;
        logic          e_busy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // T1: 3-word packet A,B,C, sink always ready.
        vecs[0]  = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        // T3: 1-word packet 0x5, sink stalls 4 cycles then takes it.
        vecs[7]  = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};

        // Reset state.
        rst_n      = 1'b0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        chk("rst_s_ready", int'(s_if.ready), 1);
        chk("rst_m_valid", int'(m_if.valid), 0);
        chk("rst_m_last", int'(m_if.last), 0);
        chk("rst_trunc", int'(trunc), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge wclk);
        #1;

        // T1 and T3 from the table.
        for (int i = 0; i < 14; i++) begin
            s_if.valid = vecs[i].sv;
            s_if.data  = vecs[i].sd;
            s_if.last  = vecs[i].sl;
            m_if.ready = vecs[i].mr;
            @(negedge wclk);
            chk($sformatf("v%0d_s_ready", i), int'(s_if.ready), int'(vecs[i].e_sready));
            chk($sformatf("v%0d_m_valid", i), int'(m_if.valid), int'(vecs[i].e_mvalid));
            chk($sformatf("v%0d_m_last", i), int'(m_if.last), int'(vecs[i].e_mlast));
            chk($sformatf("v%0d_trunc", i), int'(trunc), int'(vecs[i].e_trunc));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            if (vecs[i].chk_d) chk($sformatf("v%0d_m_data", i), int'(m_if.data),
                                   int'(vecs[i].e_mdata));
            @(posedge wclk);
            #1;
        end
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;

        // T2: 32 words without s_last are cut; the following word is a new packet.
        model_clear();
        mon_en = 1'b1;
        for (int i = 0; i < 32; i++) in_q.push_back('{data: DW'(i), last: 1'b0});
        in_q.push_back('{data: 4'h9, last: 1'b1});
        drive_stream(100, 100, 200);
        chk("t2_trunc_count", trunc_seen, 1);

        // T6: source keeps s_valid high through DRAIN; held word must survive untouched.
        for (int i = 0; i < 4; i++) in_q.push_back('{data: DW'(4'h1 + i), last: (i == 3)});
        for (int i = 0; i < 3; i++) in_q.push_back('{data: DW'(4'hE - i), last: (i == 2)});
        drive_stream(100, 100, 100);
        drive_stream(100, 40, 100);

        // T5: reset during DRAIN of a 10-word packet after 4 words have left.
        mon_en = 1'b0;
        model_clear();
        for (int i = 0; i < 10; i++) begin
            s_if.valid = 1'b1;
            s_if.data  = DW'(i * 3 + 1);
            s_if.last  = (i == 9);
            m_if.ready = 1'b0;
            @(posedge wclk);
            #1;
        end
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_if.ready = 1'b1;
            @(negedge wclk);
            chk("t5_pre_valid", int'(m_if.valid), 1);
            chk("t5_pre_data", int'(m_if.data), (k * 3 + 1) & 15);
            @(posedge wclk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_m_valid", int'(m_if.valid), 0);
        chk("t5_rst_s_ready", int'(s_if.ready), 1);
        chk("t5_rst_busy", int'(busy), 0);
        m_if.ready = 1'b0;
        @(posedge wclk);
        @(negedge wclk);
        rst_n = 1'b1;
        @(posedge wclk);
        #1;
        chk("t5_post_s_ready", int'(s_if.ready), 1);
        chk("t5_post_m_valid", int'(m_if.valid), 0);
        mon_en = 1'b1;
        in_q.push_back('{data: 4'h6, last: 1'b0});
        in_q.push_back('{data: 4'h0, last: 1'b0});
        in_q.push_back('{data: 4'hF, last: 1'b1});
        drive_stream(100, 100, 100);

        // T4: 1000 random packets of 1..40 words with random gaps and back-pressure.
        for (int p = 0; p < 1000; p++) begin
            int len;
            len = $urandom_range(40, 1);
            for (int i = 0; i < len; i++) begin
                in_q.push_back('{data: DW'($urandom_range(15)), last: (i == len - 1)});
            end
        end
        drive_stream(85, 80, 90000);
        chk("t4_drained", exp_q.size(), 0);
        chk("trunc_total", trunc_seen, trunc_exp);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
